// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM port arbiter.
//   addr_t / data_t : 32-bit address and data words
//   idx_w(n)        : width of an index into n requesters, never less than 1
//   addr_bad(...)   : window and word-alignment check for one byte address
package rom_arb_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Returns 1 when addr lies outside [base, base + 4*words) or is not word
  // aligned. Everything is widened to 33 bits so a window that ends exactly
  // at 2^32 does not wrap to zero and reject every address.
  function automatic logic addr_bad(input addr_t addr, input addr_t base,
                                    input int unsigned words);
    logic [32:0] a_w;
    logic [32:0] lo_w;
    logic [32:0] hi_w;
    a_w  = {1'b0, addr};
    lo_w = {1'b0, base};
    hi_w = lo_w + ({1'b0, words} << 2);
    return (a_w < lo_w) || (a_w >= hi_w) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_picker.sv
// Combinational round-robin one-hot selector.
//   req : request vector
//   ptr : index that currently has highest priority
//   en  : when low, nothing is granted
//   gnt : one-hot grant (all zero when nothing is granted)
//   idx : binary index of the granted requester (0 when none)
//   any : at least one requester granted
// The search visits ptr, ptr+1, ... wrapping modulo N and takes the first hit.
module rr_picker
  import rom_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Rotating priority search starting at ptr.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s      = IW'((int'(ptr) + k) % N);
      hit_s       = en & ~any & req[cand_s];
      gnt[cand_s] = gnt[cand_s] | hit_s;
      idx         = hit_s ? cand_s : idx;
      any         = any | hit_s;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-ported read-only memory (registered read data, one cycle
// latency) between NREQ read requesters with per-cycle round-robin grants.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_req / i_addr      : per-requester request and byte address (held until granted)
//   o_gnt               : one-hot grant, address accepted this cycle
//   o_rvalid            : one-hot response valid, cycle after grant (or after stall)
//   o_rdata / o_rerr    : shared response data and error, qualified by o_rvalid
//   o_haddr             : address to the memory
//   i_hrdata / i_hresp / i_hready : memory read data, error and ready
// Address phase and data phase overlap, so one read completes per cycle.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int    NREQ  = 2,
  parameter int    WORDS = 512,
  parameter addr_t BASE  = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  addr_t [NREQ-1:0] i_addr,
  output logic [NREQ-1:0] o_gnt,
  output logic [NREQ-1:0] o_rvalid,
  output data_t           o_rdata,
  output logic            o_rerr,
  output addr_t           o_haddr,
  input  data_t           i_hrdata,
  input  logic            i_hresp,
  input  logic            i_hready
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   ptr_nxt_s;
  logic [IW-1:0]   gnt_idx_s;
  logic [NREQ-1:0] gnt_s;
  logic [NREQ-1:0] owner_r;
  logic            gnt_any_s;
  logic            pick_en_s;
  logic            valid_r;
  logic            err_r;
  logic            rsp_fire_s;
  logic            addr_err_s;
  addr_t           haddr_r;
  addr_t           sel_addr_s;

  // No grant while the memory stalls or while reset is asserted, so nothing
  // new enters the pipe that the reset would have to discard.
  assign pick_en_s = i_hready & ~i_rst;

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .req (i_req),
    .ptr (ptr_r),
    .en  (pick_en_s),
    .gnt (gnt_s),
    .idx (gnt_idx_s),
    .any (gnt_any_s)
  );

  // Address phase: selected address, its check, next pointer and haddr mux.
  always_comb begin
    sel_addr_s = i_addr[gnt_idx_s];
    addr_err_s = addr_bad(sel_addr_s, BASE, WORDS);
    o_gnt      = gnt_s;
    if (gnt_idx_s == IW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + IW'(1);
    end
    // The memory sees the granted address directly; between grants it sees
    // the last one from haddr_r so the bus never floats.
    if (gnt_any_s) begin
      o_haddr = sel_addr_s;
    end else begin
      o_haddr = haddr_r;
    end
  end

  // Round-robin pointer and held bus address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_r   <= '0;
      haddr_r <= '0;
    end else if (gnt_any_s) begin
      ptr_r   <= ptr_nxt_s;
      haddr_r <= sel_addr_s;
    end
  end

  // Data-phase tracking: owner, valid and local error advance only when the
  // memory is ready, so a stall freezes the in-flight read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_r <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (i_hready) begin
      owner_r <= gnt_s;
      valid_r <= gnt_any_s;
      err_r   <= gnt_any_s & addr_err_s;
    end
  end

  // Response routing. Reset suppresses the in-flight response in the same
  // cycle it is asserted.
  always_comb begin
    rsp_fire_s = valid_r & i_hready & ~i_rst;
    if (rsp_fire_s) begin
      o_rvalid = owner_r;
      o_rerr   = err_r | i_hresp;
      if (err_r) begin
        o_rdata = 32'h0000_0000;
      end else begin
        o_rdata = i_hrdata;
      end
    end else begin
      o_rvalid = '0;
      o_rerr   = 1'b0;
      o_rdata  = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter (NREQ=2, WORDS=512, BASE=0) with a
// memory model holding mem[k] = 32'hA000_0000 + k. The driver pushes the
// expected response of every grant into a scoreboard; the monitor pops and
// compares whenever o_rvalid is non-zero.
module tb_rom_port_arbiter;
  import rom_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [1:0]  req = 2'b00;
  addr_t [1:0] addr = '0;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  data_t       rdata;
  logic        rerr;
  addr_t       haddr;
  data_t       hrdata = 32'h0000_0000;

  always #5 clk = ~clk;

  rom_port_arbiter #(
    .NREQ  (2),
    .WORDS (512),
    .BASE  (32'h0000_0000)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_addr   (addr),
    .o_gnt    (gnt),
    .o_rvalid (rvalid),
    .o_rdata  (rdata),
    .o_rerr   (rerr),
    .o_haddr  (haddr),
    .i_hrdata (hrdata),
    .i_hresp  (hresp),
    .i_hready (hready)
  );

  // Memory: registered read, word index wraps inside the 512-word array.
  always @(posedge clk) begin
    if (hready) hrdata <= 32'hA000_0000 + {23'h0, haddr[10:2]};
  end

  typedef struct {
    logic       rst;
    logic       hrdy;
    logic [1:0] req;
    addr_t      a0;
    addr_t      a1;
    logic [1:0] gnt;
    data_t      rdata;
    logic       rerr;
    int         lat;   // cycles from grant to response; 0 = no response expected
  } vec_t;

  typedef struct {
    logic [1:0] owner;
    data_t      data;
    logic       err;
    int         due;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         started = 1'b0;
  logic [1:0] exp_gnt = 2'b00;
  addr_t      exp_haddr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, want);
    end
  endtask

  task automatic add(input logic r, input logic h, input logic [1:0] rq,
                     input addr_t x0, input addr_t x1, input logic [1:0] g,
                     input data_t d, input logic e, input int l);
    vec_t v;
    v.rst = r; v.hrdy = h; v.req = rq; v.a0 = x0; v.a1 = x1;
    v.gnt = g; v.rdata = d; v.rerr = e; v.lat = l;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = v.rst;
    hready  = v.hrdy;
    req     = v.req;
    addr[0] = v.a0;
    addr[1] = v.a1;
    cyc++;
    exp_gnt   = v.gnt;
    exp_haddr = v.gnt[1] ? v.a1 : v.a0;
    started   = 1'b1;
    if (v.rst) begin
      sb.delete();
    end else if (v.gnt != 2'b00 && v.lat != 0) begin
      e.owner = v.gnt;
      e.data  = v.rdata;
      e.err   = v.rerr;
      e.due   = cyc + v.lat;
      sb.push_back(e);
    end
  endtask

  // Monitor: per-cycle grant check, scoreboard pop on every response.
  always @(negedge clk) begin
    if (started) begin
      check("gnt", {30'h0, gnt}, {30'h0, exp_gnt});
      if (gnt != 2'b00) check("haddr", haddr, exp_haddr);
      if (rvalid != 2'b00) begin
        if (sb.size() == 0) begin
          check("rvalid_unexpected", {30'h0, rvalid}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("rvalid_owner", {30'h0, rvalid}, {30'h0, mon_e.owner});
          check("rdata", rdata, mon_e.data);
          check("rerr", {31'h0, rerr}, {31'h0, mon_e.err});
          check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
    end
  end

  initial begin
    // reset, then idle
    add(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    add(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    add(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    // contention from pointer 0: 01,10,01,10
    add(1'b0, 1'b1, 2'b11, 32'h0, 32'h4, 2'b01, 32'hA000_0000, 1'b0, 1);
    add(1'b0, 1'b1, 2'b11, 32'h0, 32'h4, 2'b10, 32'hA000_0001, 1'b0, 1);
    add(1'b0, 1'b1, 2'b11, 32'h0, 32'h4, 2'b01, 32'hA000_0000, 1'b0, 1);
    add(1'b0, 1'b1, 2'b11, 32'h0, 32'h4, 2'b10, 32'hA000_0001, 1'b0, 1);
    // single requester at 0x10
    add(1'b0, 1'b1, 2'b01, 32'h10, 32'h0, 2'b01, 32'hA000_0004, 1'b0, 1);
    add(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    // errors: end of window, misaligned, top of space; then last valid word
    add(1'b0, 1'b1, 2'b10, 32'h0, 32'h800, 2'b10, 32'h0, 1'b1, 1);
    add(1'b0, 1'b1, 2'b01, 32'h6, 32'h0, 2'b01, 32'h0, 1'b1, 1);
    add(1'b0, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 2'b10, 32'h0, 1'b1, 1);
    add(1'b0, 1'b1, 2'b01, 32'h7FC, 32'h0, 2'b01, 32'hA000_01FF, 1'b0, 1);
    add(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    // hready stall for two cycles; requester 1 waits and is granted on release
    add(1'b0, 1'b1, 2'b01, 32'h20, 32'h0, 2'b01, 32'hA000_0008, 1'b0, 3);
    add(1'b0, 1'b0, 2'b10, 32'h0, 32'h24, 2'b00, 32'h0, 1'b0, 0);
    add(1'b0, 1'b0, 2'b10, 32'h0, 32'h24, 2'b00, 32'h0, 1'b0, 0);
    add(1'b0, 1'b1, 2'b10, 32'h0, 32'h24, 2'b10, 32'hA000_0009, 1'b0, 1);
    add(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    // reset mid-flight: response of 0x30 discarded, pointer back to 0
    add(1'b0, 1'b1, 2'b01, 32'h30, 32'h0, 2'b01, 32'h0, 1'b0, 0);
    add(1'b1, 1'b1, 2'b11, 32'h34, 32'h38, 2'b00, 32'h0, 1'b0, 0);
    add(1'b0, 1'b1, 2'b11, 32'h34, 32'h38, 2'b01, 32'hA000_000D, 1'b0, 1);
    add(1'b0, 1'b1, 2'b10, 32'h34, 32'h38, 2'b10, 32'hA000_000E, 1'b0, 1);
    add(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    // streaming 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      add(1'b0, 1'b1, 2'b01, 32'(i * 4), 32'h0, 2'b01, 32'hA000_0000 + 32'(i), 1'b0, 1);
    end
    add(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);
    add(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      if (i == 2) begin
        #3;
        check("reset_gnt", {30'h0, gnt}, 32'h0);
        check("reset_rvalid", {30'h0, rvalid}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_rerr", {31'h0, rerr}, 32'h0);
        check("reset_haddr", haddr, 32'h0);
      end
    end

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
